// File: rtl/pmem_arbiter_n_pkg.sv
// Shared types for the N-port line-granular memory arbiter.
package pmem_arbiter_n_pkg;

    localparam int unsigned ARB_MAX_PORTS   = 8;
    localparam int unsigned PMEM_LINE_WIDTH = 128;
    localparam int unsigned PMEM_ADDR_WIDTH = 16;

    typedef logic [PMEM_LINE_WIDTH-1:0] lc3b_pmem_line;
    typedef logic [PMEM_ADDR_WIDTH-1:0] lc3b_pmem_addr;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_DONE
    } arb_state_t;

    // Grant index width; a single port still gets a 1-bit index.
    function automatic int unsigned grant_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pmem_arbiter_n_rr_pick.sv
// Combinational winner selection: rotating search from rr_ptr (mode=1) or from index 0 (mode=0).
module pmem_arbiter_n_rr_pick #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned GW        = 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [GW-1:0]        rr_ptr,
    input  logic                 mode,
    output logic [GW-1:0]        grant,
    output logic                 grant_valid
);

    always_comb begin
        logic [31:0] base;
        logic [31:0] idx;
        grant       = '0;
        grant_valid = 1'b0;
        base        = mode ? 32'(rr_ptr) : 32'd0;
        idx         = 32'd0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = (base + 32'(k)) % 32'(NUM_PORTS);
            if (!grant_valid && |(req & (NUM_PORTS'(1) << idx))) begin
                grant       = GW'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pmem_arbiter_n.sv
// Serialises whole-line read/write transactions from N L1 ports onto one memory port,
// one transaction in flight, with fixed-priority or round-robin grant.
module pmem_arbiter_n
    import pmem_arbiter_n_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned LINE_WIDTH = $bits(lc3b_pmem_line),
    parameter int unsigned ADDR_WIDTH = $bits(lc3b_pmem_addr),
    parameter bit          RR_MODE    = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_PORTS-1:0]                 port_read,
    input  logic [NUM_PORTS-1:0]                 port_write,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] port_address,
    input  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0] port_wdata,
    output logic [NUM_PORTS-1:0]                 port_resp,
    output logic [LINE_WIDTH-1:0]                port_rdata,
    output logic                                 mem_read,
    output logic                                 mem_write,
    output logic [ADDR_WIDTH-1:0]                mem_address,
    output logic [LINE_WIDTH-1:0]                mem_wdata,
    input  logic                                 mem_resp,
    input  logic [LINE_WIDTH-1:0]                mem_rdata,
    output logic                                 busy
);

    localparam int unsigned GW = grant_width(NUM_PORTS);

    arb_state_t           state;
    arb_state_t           state_d;
    logic [NUM_PORTS-1:0] req;
    logic [GW-1:0]        rr_ptr;
    logic [GW-1:0]        rr_next;
    logic [GW-1:0]        gnt_q;
    logic [GW-1:0]        pick_idx;
    logic                 pick_valid;
    logic                 grant_en;
    logic                 finish;

    assign req     = port_read | port_write;
    assign rr_next = (32'(pick_idx) == 32'(NUM_PORTS - 1)) ? '0 : pick_idx + GW'(1);

    pmem_arbiter_n_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .GW        (GW)
    ) u_rr_pick (
        .req         (req),
        .rr_ptr      (rr_ptr),
        .mode        (RR_MODE),
        .grant       (pick_idx),
        .grant_valid (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        grant_en = 1'b0;
        finish   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d  = ARB_BUSY;
                    grant_en = 1'b1;
                end
            end
            ARB_BUSY: begin
                if (mem_resp) begin
                    state_d = ARB_DONE;
                    finish  = 1'b1;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Request latch and registered outputs; a write wins when a port raises both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            gnt_q       <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            port_rdata  <= '0;
            port_resp   <= '0;
            busy        <= 1'b0;
        end else begin
            if (grant_en) begin
                gnt_q       <= pick_idx;
                mem_write   <= port_write[pick_idx];
                mem_read    <= !port_write[pick_idx];
                mem_address <= port_address[pick_idx];
                mem_wdata   <= port_wdata[pick_idx];
                if (RR_MODE) begin
                    rr_ptr <= rr_next;
                end
            end
            if (finish) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
                if (mem_read) begin
                    port_rdata <= mem_rdata;
                end
            end
            port_resp <= finish ? (NUM_PORTS'(1) << gnt_q) : '0;
            busy      <= (state_d != ARB_IDLE);
        end
    end

    a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(|(port_read & port_write)));

endmodule

// File: tb/tb_pmem_arbiter_n.sv
// Scoreboard bench for pmem_arbiter_n: 2-port round-robin, 2-port fixed priority and 4-port round-robin instances.
module tb_pmem_arbiter_n;

    typedef struct {
        int           port;
        bit           wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
    } txn_t;

    logic              clk;
    logic              rst_n;
    logic [3:0]        port_read;
    logic [3:0]        port_write;
    logic [3:0][15:0]  port_address;
    logic [3:0][127:0] port_wdata;
    logic              mem_resp;
    logic [127:0]      mem_rdata;

    logic [1:0]   a_resp, b_resp;
    logic [3:0]   c_resp;
    logic [127:0] a_rdata, b_rdata, c_rdata, a_mwdata, b_mwdata, c_mwdata;
    logic [15:0]  a_maddr, b_maddr, c_maddr;
    logic         a_mread, b_mread, c_mread, a_mwrite, b_mwrite, c_mwrite;
    logic         a_busy, b_busy, c_busy;

    logic [3:0]   s_resp;
    logic [127:0] s_rdata, s_mwdata;
    logic [15:0]  s_maddr;
    logic         s_mread, s_mwrite, s_busy;

    int           sel;
    int           n_checks;
    int           n_fail;
    logic [127:0] last_rd;
    txn_t         sb[$];

    pmem_arbiter_n #(.NUM_PORTS(2), .LINE_WIDTH(128), .ADDR_WIDTH(16), .RR_MODE(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .port_read(port_read[1:0]), .port_write(port_write[1:0]),
        .port_address(port_address[1:0]), .port_wdata(port_wdata[1:0]), .port_resp(a_resp),
        .port_rdata(a_rdata), .mem_read(a_mread), .mem_write(a_mwrite), .mem_address(a_maddr),
        .mem_wdata(a_mwdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata), .busy(a_busy));

    pmem_arbiter_n #(.NUM_PORTS(2), .LINE_WIDTH(128), .ADDR_WIDTH(16), .RR_MODE(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .port_read(port_read[1:0]), .port_write(port_write[1:0]),
        .port_address(port_address[1:0]), .port_wdata(port_wdata[1:0]), .port_resp(b_resp),
        .port_rdata(b_rdata), .mem_read(b_mread), .mem_write(b_mwrite), .mem_address(b_maddr),
        .mem_wdata(b_mwdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata), .busy(b_busy));

    pmem_arbiter_n #(.NUM_PORTS(4), .LINE_WIDTH(128), .ADDR_WIDTH(16), .RR_MODE(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .port_read(port_read), .port_write(port_write),
        .port_address(port_address), .port_wdata(port_wdata), .port_resp(c_resp),
        .port_rdata(c_rdata), .mem_read(c_mread), .mem_write(c_mwrite), .mem_address(c_maddr),
        .mem_wdata(c_mwdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata), .busy(c_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route the instance under test onto one set of observation signals.
    always_comb begin
        s_resp = {2'b00, a_resp}; s_rdata = a_rdata; s_mwdata = a_mwdata; s_maddr = a_maddr;
        s_mread = a_mread; s_mwrite = a_mwrite; s_busy = a_busy;
        if (sel == 1) begin
            s_resp = {2'b00, b_resp}; s_rdata = b_rdata; s_mwdata = b_mwdata; s_maddr = b_maddr;
            s_mread = b_mread; s_mwrite = b_mwrite; s_busy = b_busy;
        end else if (sel == 2) begin
            s_resp = c_resp; s_rdata = c_rdata; s_mwdata = c_mwdata; s_maddr = c_maddr;
            s_mread = c_mread; s_mwrite = c_mwrite; s_busy = c_busy;
        end
    end

    function automatic void expect_txn(input int p, input bit wr, input logic [15:0] a,
                                       input logic [127:0] wd, input logic [127:0] rd);
        txn_t t;
        t.port = p; t.wr = wr; t.addr = a; t.wdata = wd; t.rdata = rd;
        sb.push_back(t);
    endfunction

    task automatic drive_req(input int p, input bit wr, input logic [15:0] a, input logic [127:0] wd);
        port_read[p]    = !wr;
        port_write[p]   = wr;
        port_address[p] = a;
        port_wdata[p]   = wd;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; port_read = '0; port_write = '0; mem_resp = 1'b0;
        sb.delete(); last_rd = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Serve the oldest expected transaction as the downstream memory and check the completion.
    task automatic run_txn(input int wait_cyc, input bit drop);
        txn_t         t;
        int           n;
        logic [127:0] exp_rd;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: no expected transaction queued");
            return;
        end
        t = sb.pop_front();
        n = 0;
        while (!(s_mread || s_mwrite) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_fail++;
            $display("FAIL mem_req_timeout: port %0d got no mem_read/mem_write in 20 cycles", t.port);
            return;
        end
        n_checks++;
        if ({s_mwrite, s_mread} !== {t.wr, !t.wr} || s_maddr !== t.addr) begin
            n_fail++;
            $display("FAIL mem_cmd port %0d: got wr=%b rd=%b addr=%h, expected wr=%b rd=%b addr=%h",
                     t.port, s_mwrite, s_mread, s_maddr, t.wr, !t.wr, t.addr);
        end
        if (t.wr) begin
            n_checks++;
            if (s_mwdata !== t.wdata) begin
                n_fail++;
                $display("FAIL mem_wdata port %0d: got %h expected %h", t.port, s_mwdata, t.wdata);
            end
        end
        for (int k = 0; k < wait_cyc; k++) begin
            @(negedge clk);
            n_checks++;
            if (s_maddr !== t.addr || {s_mwrite, s_mread} !== {t.wr, !t.wr} || s_resp !== 4'b0) begin
                n_fail++;
                $display("FAIL busy_hold cycle %0d: got addr=%h wr=%b rd=%b resp=%b expected addr=%h wr=%b rd=%b resp=0000",
                         k, s_maddr, s_mwrite, s_mread, s_resp, t.addr, t.wr, !t.wr);
            end
        end
        mem_resp  = 1'b1;
        mem_rdata = t.rdata;
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = {4{$urandom}};
        n_checks++;
        if (s_resp !== (4'b0001 << t.port)) begin
            n_fail++;
            $display("FAIL port_resp: got %b expected %b", s_resp, 4'b0001 << t.port);
        end
        n_checks++;
        if (s_mread !== 1'b0 || s_mwrite !== 1'b0 || s_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL done_state: got rd=%b wr=%b busy=%b expected rd=0 wr=0 busy=1",
                     s_mread, s_mwrite, s_busy);
        end
        exp_rd = t.wr ? last_rd : t.rdata;
        n_checks++;
        if (s_rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL port_rdata port %0d: got %h expected %h", t.port, s_rdata, exp_rd);
        end
        last_rd = exp_rd;
        if (drop) begin
            port_read[t.port]  = 1'b0;
            port_write[t.port] = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (s_resp !== 4'b0) begin
            n_fail++;
            $display("FAIL port_resp_width: got %b expected 0000 one cycle after completion", s_resp);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({a_mread, a_mwrite, a_resp, a_busy, a_maddr, a_mwdata, a_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: got rd=%b wr=%b resp=%b busy=%b addr=%h expected all zero",
                     a_mread, a_mwrite, a_resp, a_busy, a_maddr);
        end
        n_checks++;
        if ({b_mread, b_mwrite, b_resp, b_busy, b_maddr, b_mwdata, b_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_b: got rd=%b wr=%b resp=%b busy=%b addr=%h expected all zero",
                     b_mread, b_mwrite, b_resp, b_busy, b_maddr);
        end
        n_checks++;
        if ({c_mread, c_mwrite, c_resp, c_busy, c_maddr, c_mwdata, c_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_c: got rd=%b wr=%b resp=%b busy=%b addr=%h expected all zero",
                     c_mread, c_mwrite, c_resp, c_busy, c_maddr);
        end
    endtask

    task automatic test_single_read();
        apply_reset();
        sel = 0;
        drive_req(0, 1'b0, 16'h0040, '0);
        expect_txn(0, 1'b0, 16'h0040, '0, {16{8'hA5}});
        @(negedge clk);
        n_checks++;
        if (s_mread !== 1'b1 || s_mwrite !== 1'b0 || s_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL read_latency: got rd=%b wr=%b busy=%b expected rd=1 wr=0 busy=1",
                     s_mread, s_mwrite, s_busy);
        end
        run_txn(5, 1'b1);
    endtask

    task automatic test_rr_pair();
        apply_reset();
        sel = 0;
        drive_req(0, 1'b0, 16'h0040, '0);
        drive_req(1, 1'b1, 16'h0080, 128'h1234);
        expect_txn(0, 1'b0, 16'h0040, '0, {4{32'h0BADF00D}});
        expect_txn(1, 1'b1, 16'h0080, 128'h1234, {4{32'hDEADBEEF}});
        run_txn(2, 1'b1);
        run_txn(0, 1'b1);
        n_checks++;
        if (dut_a.rr_ptr !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_ptr_final: got %0d expected 0", dut_a.rr_ptr);
        end
    endtask

    task automatic test_fixed_priority();
        apply_reset();
        sel = 1;
        drive_req(0, 1'b0, 16'h0040, '0);
        drive_req(1, 1'b1, 16'h0080, 128'h1234);
        for (int r = 0; r < 3; r++) begin
            expect_txn(0, 1'b0, 16'h0040, '0, {4{32'h00C0FFEE + 32'(r)}});
        end
        expect_txn(1, 1'b1, 16'h0080, 128'h1234, {4{32'h55555555}});
        run_txn(1, 1'b0);
        run_txn(0, 1'b0);
        run_txn(0, 1'b1);
        run_txn(1, 1'b1);
    endtask

    task automatic test_four_port_rr();
        apply_reset();
        sel = 2;
        for (int p = 0; p < 4; p++) begin
            drive_req(p, p[0], 16'h1000 + 16'(p * 16), {4{32'hC0DE0000 + 32'(p)}});
        end
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 4; p++) begin
                expect_txn(p, p[0], 16'h1000 + 16'(p * 16), {4{32'hC0DE0000 + 32'(p)}},
                           {4{32'h5A000000 + 32'(r * 4 + p)}});
            end
        end
        for (int i = 0; i < 8; i++) begin
            run_txn(i % 3, 1'b0);
        end
        port_read  = '0;
        port_write = '0;
    endtask

    task automatic test_reset_abort();
        apply_reset();
        sel = 0;
        drive_req(0, 1'b0, 16'h0300, '0);
        drive_req(1, 1'b0, 16'h0310, '0);
        @(negedge clk);
        n_checks++;
        if (s_mread !== 1'b1 || s_maddr !== 16'h0300) begin
            n_fail++;
            $display("FAIL abort_setup: got rd=%b addr=%h expected rd=1 addr=0300", s_mread, s_maddr);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (s_mread !== 1'b0 || s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_abort: got rd=%b busy=%b expected rd=0 busy=0", s_mread, s_busy);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (s_resp !== 4'b0 || s_mread !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_no_resp cycle %0d: got resp=%b rd=%b expected resp=0000 rd=0",
                         k, s_resp, s_mread);
            end
        end
        last_rd = '0;
        rst_n   = 1'b1;
        expect_txn(0, 1'b0, 16'h0300, '0, {4{32'h30303030}});
        expect_txn(1, 1'b0, 16'h0310, '0, {4{32'h31313131}});
        run_txn(1, 1'b1);
        run_txn(0, 1'b1);
    endtask

    task automatic test_addr_hold_stray_resp();
        apply_reset();
        sel = 0;
        drive_req(0, 1'b0, 16'h0100, '0);
        expect_txn(0, 1'b0, 16'h0100, '0, {8{16'h1111}});
        @(negedge clk);
        port_address[0] = 16'h0200;
        port_wdata[0]   = {4{$urandom}};
        run_txn(4, 1'b1);
        mem_resp  = 1'b1;
        mem_rdata = {4{32'h77777777}};
        @(negedge clk);
        mem_resp = 1'b0;
        n_checks++;
        if (s_resp !== 4'b0 || s_mread !== 1'b0 || s_mwrite !== 1'b0 || s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_resp_state: got resp=%b rd=%b wr=%b busy=%b expected all zero",
                     s_resp, s_mread, s_mwrite, s_busy);
        end
        @(negedge clk);
        n_checks++;
        if (s_rdata !== last_rd || s_resp !== 4'b0) begin
            n_fail++;
            $display("FAIL stray_resp_data: got rdata=%h resp=%b expected rdata=%h resp=0000",
                     s_rdata, s_resp, last_rd);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        port_read    = '0;
        port_write   = '0;
        port_address = '0;
        port_wdata   = '0;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        sel          = 0;
        n_checks     = 0;
        n_fail       = 0;
        last_rd      = '0;
        test_reset();
        test_single_read();
        test_rr_pair();
        test_fixed_priority();
        test_four_port_rr();
        test_reset_abort();
        test_addr_hold_stray_resp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before the sequence completed");
        $fatal(1, "watchdog");
    end

endmodule
